fxp_to_bcd: RTL and testbench

FXP_TO_BCD -- requirements
Module: fxp_to_bcd

---
 rtl/fxp_to_bcd.sv | 166 ++++++++++++++++
 tb/tb_fxp_to_bcd.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_to_bcd.sv
// Signed fixed-point to sign + BCD converter: double-dabble for the integer part,
// multiply-by-ten digit extraction for the fraction. Optional rounding: FXP_BCD_ROUND_EN.
`timescale 1ns/1ps
module fxp_to_bcd #(
  parameter int INT_W       = 14,
  parameter int FRAC_W      = 12,
  parameter int INT_DIGITS  = 5,
  parameter int FRAC_DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INT_W+FRAC_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [4*INT_DIGITS-1:0]  out_int_bcd,
  output logic [4*FRAC_DIGITS-1:0] out_frac_bcd,
  output logic                     busy
);

  localparam int W     = INT_W + FRAC_W;
  localparam int ID_W  = 4 * INT_DIGITS;
  localparam int FD_W  = 4 * FRAC_DIGITS;
  localparam int CNT_W = $clog2(INT_W + FRAC_DIGITS + 2);

`ifdef FXP_BCD_ROUND_EN
  typedef enum logic [2:0] {S_IDLE, S_INT, S_FRAC, S_ROUND, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_INT, S_FRAC, S_DONE} state_t;
`endif

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [INT_W-1:0]   int_sh;
  logic [ID_W-1:0]    bcd_int;
  logic [ID_W-1:0]    bcd_adj;
  logic [FRAC_W-1:0]  frac_acc;
  logic [FD_W-1:0]    frac_dig;
  logic [FRAC_W+3:0]  f10;
  logic [W-1:0]       mag;
  logic               last_int;
  logic               last_frac;

  function automatic logic [ID_W-1:0] dd_adjust(input logic [ID_W-1:0] b);
    logic [ID_W-1:0] r;
    r = b;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef FXP_BCD_ROUND_EN
  logic [3:0] rnd_dig;

  // Decimal +1 across the whole integer.fraction digit string.
  function automatic logic [ID_W+FD_W-1:0] bcd_inc(input logic [ID_W+FD_W-1:0] b);
    logic [ID_W+FD_W-1:0] r;
    logic                 carry;
    r     = b;
    carry = 1'b1;
    for (int i = 0; i < INT_DIGITS + FRAC_DIGITS; i++) begin
      if (carry) begin
        if (b[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = b[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction
`endif

  // Two's-complement negate of the most negative value yields 2^(W-1), which fits unsigned.
  assign mag       = in_data[W-1] ? (~in_data + W'(1)) : in_data;
  assign bcd_adj   = dd_adjust(bcd_int);
  assign f10       = {1'b0, frac_acc, 3'b000} + {3'b000, frac_acc, 1'b0};
  assign last_int  = (cnt == CNT_W'(INT_W - 1));
  assign last_frac = (cnt == CNT_W'(FRAC_DIGITS));

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_INT;
      S_INT:   if (last_int) state_nx = S_FRAC;
`ifdef FXP_BCD_ROUND_EN
      S_FRAC:  if (last_frac) state_nx = S_ROUND;
      S_ROUND: state_nx = S_DONE;
`else
      S_FRAC:  if (last_frac) state_nx = S_DONE;
`endif
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The final FRAC cycle (cnt == FRAC_DIGITS) is the commit cycle: no digit is shifted in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      int_sh       <= '0;
      bcd_int      <= '0;
      frac_acc     <= '0;
      frac_dig     <= '0;
      out_sign     <= 1'b0;
      out_int_bcd  <= '0;
      out_frac_bcd <= '0;
`ifdef FXP_BCD_ROUND_EN
      rnd_dig      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            out_sign <= in_data[W-1];
            int_sh   <= mag[W-1:FRAC_W];
            frac_acc <= mag[FRAC_W-1:0];
            bcd_int  <= '0;
            frac_dig <= '0;
            cnt      <= '0;
          end
        end
        S_INT: begin
          bcd_int <= (bcd_adj << 1) | ID_W'(int_sh[INT_W-1]);
          int_sh  <= int_sh << 1;
          cnt     <= last_int ? '0 : cnt + 1'b1;
        end
        S_FRAC: begin
          if (!last_frac) begin
            frac_dig <= (frac_dig << 4) | FD_W'(f10[FRAC_W+3:FRAC_W]);
            frac_acc <= f10[FRAC_W-1:0];
            cnt      <= cnt + 1'b1;
          end else begin
`ifdef FXP_BCD_ROUND_EN
            rnd_dig      <= f10[FRAC_W+3:FRAC_W];
`else
            out_int_bcd  <= bcd_int;
            out_frac_bcd <= frac_dig;
`endif
          end
        end
`ifdef FXP_BCD_ROUND_EN
        S_ROUND: begin
          if (rnd_dig >= 4'd5) {out_int_bcd, out_frac_bcd} <= bcd_inc({bcd_int, frac_dig});
          else                 {out_int_bcd, out_frac_bcd} <= {bcd_int, frac_dig};
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_to_bcd.sv
// Bench for fxp_to_bcd: directed spec vectors, random vectors against an arithmetic model,
// backpressure, mid-conversion reset and back-to-back handoff.
`timescale 1ns/1ps
module tb_fxp_to_bcd;
  localparam int INT_W = 14, FRAC_W = 12, INT_DIGITS = 5, FRAC_DIGITS = 4;
  localparam int W = INT_W + FRAC_W;
`ifdef FXP_BCD_ROUND_EN
  localparam int LAT = INT_W + FRAC_DIGITS + 2;
`else
  localparam int LAT = INT_W + FRAC_DIGITS + 1;
`endif

  logic                     clk, reset_n, in_valid, in_ready, out_valid, out_ready, out_sign, busy;
  logic [W-1:0]             in_data;
  logic [4*INT_DIGITS-1:0]  out_int_bcd;
  logic [4*FRAC_DIGITS-1:0] out_frac_bcd;

  int n_vec = 0;
  int n_err = 0;

  fxp_to_bcd #(.INT_W(INT_W), .FRAC_W(FRAC_W), .INT_DIGITS(INT_DIGITS), .FRAC_DIGITS(FRAC_DIGITS)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_int_bcd(out_int_bcd), .out_frac_bcd(out_frac_bcd), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on the real value |x| = ip + fp/2^FRAC_W.
  function automatic void model(input logic [W-1:0] d, output logic s,
                                output logic [4*INT_DIGITS-1:0] ib, output logic [4*FRAC_DIGITS-1:0] fb);
    logic signed [W-1:0] ds;
    longint v, mag, ip, fp, fr, scale, p10;
    ds = d;
    v = longint'(ds);
    s = (v < 0);
    mag = s ? -v : v;
    scale = longint'(1) << FRAC_W;
    ip = mag / scale;
    fp = mag % scale;
    fr = 0;
    p10 = 1;
    for (int k = 0; k < FRAC_DIGITS; k++) begin
      fp = fp * 10;
      fr = fr * 10 + fp / scale;
      fp = fp % scale;
      p10 = p10 * 10;
    end
`ifdef FXP_BCD_ROUND_EN
    fp = fp * 10;
    if (fp / scale >= 5) begin
      fr = fr + 1;
      if (fr == p10) begin
        fr = 0;
        ip = ip + 1;
      end
    end
`endif
    ib = '0;
    fb = '0;
    for (int i = 0; i < INT_DIGITS; i++) begin
      ib[4*i +: 4] = 4'(ip % 10);
      ip = ip / 10;
    end
    for (int i = 0; i < FRAC_DIGITS; i++) begin
      fb[4*i +: 4] = 4'(fr % 10);
      fr = fr / 10;
    end
  endfunction

  task automatic start(input logic [W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_ready data=%h in_ready=%b want 1", d, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (out_valid !== 1'b1 && lat < 200);
  endtask

  task automatic convert(input string name, input logic [W-1:0] d, input logic es,
                         input logic [4*INT_DIGITS-1:0] ei, input logic [4*FRAC_DIGITS-1:0] ef);
    int lat;
    start(d);
    wait_valid(lat);
    n_vec++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL %s_latency data=%h got %0d want %0d", name, d, lat, LAT);
    end
    n_vec++;
    if (out_sign !== es || out_int_bcd !== ei || out_frac_bcd !== ef) begin
      n_err++;
      $display("FAIL %s_result data=%h got s=%b %h.%h want s=%b %h.%h",
               name, d, out_sign, out_int_bcd, out_frac_bcd, es, ei, ef);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_handoff got valid=%b ready=%b want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    n_vec++;
    if (out_valid !== 1'b0 || out_sign !== 1'b0 || out_int_bcd !== '0 || out_frac_bcd !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got v=%b s=%b %h.%h busy=%b want all 0",
               out_valid, out_sign, out_int_bcd, out_frac_bcd, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
`ifdef FXP_BCD_ROUND_EN
    localparam logic [15:0] MAX_FRAC = 16'h9998;
`else
    localparam logic [15:0] MAX_FRAC = 16'h9997;
`endif
    convert("p3_25",  26'h0003400, 1'b0, 20'h00003, 16'h2500);
    convert("m1_5",   26'h3FFE800, 1'b1, 20'h00001, 16'h5000);
    convert("min",    26'h2000000, 1'b1, 20'h08192, 16'h0000);
    convert("max",    26'h1FFFFFF, 1'b0, 20'h08191, MAX_FRAC);
    convert("zero",   26'h0000000, 1'b0, 20'h00000, 16'h0000);
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic es;
    logic [4*INT_DIGITS-1:0] ei;
    logic [4*FRAC_DIGITS-1:0] ef;
    for (int n = 0; n < 40; n++) begin
      d = W'($urandom);
      if (n % 10 == 3) d[W-1:FRAC_W] = '1;
      if (n % 10 == 7) d[FRAC_W-1:0] = '0;
      model(d, es, ei, ef);
      convert("random", d, es, ei, ef);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start(26'h0003400);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      in_valid = (lat == 5 || lat == 6);
      in_data  = 26'h3FFE800;
      if (lat == 5) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_busy_ready got %b want 0", in_ready);
        end
      end
    end while (out_valid !== 1'b1 && lat < 200);
    in_valid = 1'b0;
    n_vec++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL bp_latency got %0d want %0d", lat, LAT);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== 1'b0 ||
          out_int_bcd !== 20'h00003 || out_frac_bcd !== 16'h2500) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d got v=%b r=%b s=%b %h.%h want 1 0 0 00003.2500",
                 c, out_valid, in_ready, out_sign, out_int_bcd, out_frac_bcd);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release got r=%b v=%b want 1 0", in_ready, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_not_queued busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    start(26'h3FFE800);
    repeat (7) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_sign !== 1'b0 || out_int_bcd !== '0 || out_frac_bcd !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got v=%b s=%b %h.%h busy=%b want all 0",
               out_valid, out_sign, out_int_bcd, out_frac_bcd, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL mid_no_partial out_valid seen %0d times want 0", seen);
    end
    convert("post_reset", 26'h0003400, 1'b0, 20'h00003, 16'h2500);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic es;
    logic [4*INT_DIGITS-1:0] ei;
    logic [4*FRAC_DIGITS-1:0] ef;
    int lat;
    d = W'($urandom);
    start(d);
    for (int n = 0; n < 8; n++) begin
      model(d, es, ei, ef);
      wait_valid(lat);
      n_vec++;
      if (lat != LAT || out_sign !== es || out_int_bcd !== ei || out_frac_bcd !== ef) begin
        n_err++;
        $display("FAIL b2b_result data=%h lat=%0d got s=%b %h.%h want lat=%0d s=%b %h.%h",
                 d, lat, out_sign, out_int_bcd, out_frac_bcd, LAT, es, ei, ef);
      end
      d = W'($urandom);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      @(posedge clk);
      #1 out_ready = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_same_edge got busy=%b ready=%b want 0 1", busy, in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    wait_valid(lat);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
